// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encoding,
// default reset vector and the branch-target helper.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT      = 2'd1,
        ST_STEP_WAIT = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcode the decoder recognises as halt/syscall.
    localparam logic [5:0] HALT_OPCODE = 6'h10;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] offset);
        return pc4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the jump-control decoder / front panel and the sequencer.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    // Flow control: an instruction at out_pc commits (out_run = 1) in a cycle
    // where the FSM may execute, in_stall is low and in_halt is low. in_go is
    // a level sampled every cycle; held high in STEP_WAIT it steps each cycle.
    logic             in_J;
    logic             in_JW;
    logic             in_JR;
    logic             in_BEQ;
    logic             in_BNE;
    logic             in_BGEZ;
    logic             in_equal;
    logic             in_sign;
    logic [25:0]      in_target;
    logic [15:0]      in_offset;
    logic [31:0]      in_rs;
    logic             in_halt;
    logic             in_go;
    logic             in_step_mode;
    logic             in_stall;

    logic [31:0]      out_pc;
    logic [31:0]      out_link;
    logic             out_link_we;
    logic             out_run;
    logic             out_halted;
    logic [CNT_W-1:0] out_cycles;
    logic [CNT_W-1:0] out_jumps;
    logic [CNT_W-1:0] out_branches;
    seq_state_e       out_state;

    modport slave (
        input  in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ, in_equal, in_sign,
               in_target, in_offset, in_rs, in_halt, in_go, in_step_mode, in_stall,
        output out_pc, out_link, out_link_we, out_run, out_halted,
               out_cycles, out_jumps, out_branches, out_state
    );

    modport master (
        output in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ, in_equal, in_sign,
               in_target, in_offset, in_rs, in_halt, in_go, in_step_mode, in_stall,
        input  out_pc, out_link, out_link_we, out_run, out_halted,
               out_cycles, out_jumps, out_branches, out_state
    );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: JR beats J/JAL beats a taken branch beats PC+4.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        j_i,
    input  logic        jr_i,
    input  logic        beq_i,
    input  logic        bne_i,
    input  logic        bgez_i,
    input  logic        equal_i,
    input  logic        sign_i,
    input  logic [25:0] target_i,
    input  logic [15:0] offset_i,
    input  logic [31:0] rs_i,
    output logic [31:0] pc4_o,
    output logic [31:0] next_pc_o,
    output logic        taken_o
);

    always_comb begin
        pc4_o   = pc_i + 32'd4;
        taken_o = (beq_i & equal_i) | (bne_i & ~equal_i) | (bgez_i & ~sign_i);

        next_pc_o = pc4_o;
        if (jr_i) begin
            // Register targets are forced word-aligned.
            next_pc_o = rs_i & ~32'd3;
        end else if (j_i) begin
            next_pc_o = {pc4_o[31:28], target_i, 2'b00};
        end else if (taken_o) begin
            next_pc_o = branch_target(pc4_o, offset_i);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, RUN/HALT/STEP_WAIT control and
// saturating statistic counters for cycles, jumps and taken branches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    pc_sequencer_if.slave  bus
);

    seq_state_e       state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] jumps_q;
    logic [CNT_W-1:0] branches_q;

    logic [31:0]      pc4;
    logic [31:0]      next_pc;
    logic             taken;
    logic             run;

    next_pc_calc u_next_pc_calc (
        .pc_i      (pc_q),
        .j_i       (bus.in_J),
        .jr_i      (bus.in_JR),
        .beq_i     (bus.in_BEQ),
        .bne_i     (bus.in_BNE),
        .bgez_i    (bus.in_BGEZ),
        .equal_i   (bus.in_equal),
        .sign_i    (bus.in_sign),
        .target_i  (bus.in_target),
        .offset_i  (bus.in_offset),
        .rs_i      (bus.in_rs),
        .pc4_o     (pc4),
        .next_pc_o (next_pc),
        .taken_o   (taken)
    );

    always_comb begin
        run = ~bus.in_stall & ~bus.in_halt &
              ((state_q == ST_RUN) | ((state_q == ST_STEP_WAIT) & bus.in_go));
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            cycles_q   <= '0;
            jumps_q    <= '0;
            branches_q <= '0;
        end else begin
            if (state_q != ST_HALT && cycles_q != '1) begin
                cycles_q <= cycles_q + 1'b1;
            end

            // run is never set in HALT, so this cannot collide with the resume load below.
            if (run) begin
                pc_q <= next_pc;
                if (bus.in_J && jumps_q != '1) begin
                    jumps_q <= jumps_q + 1'b1;
                end
                if (taken && branches_q != '1) begin
                    branches_q <= branches_q + 1'b1;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (bus.in_halt && !bus.in_stall) begin
                        state_q <= ST_HALT;
                    end else if (bus.in_step_mode && run) begin
                        state_q <= ST_STEP_WAIT;
                    end
                end
                ST_HALT: begin
                    // Resume skips over the halt instruction, even while stalled.
                    if (bus.in_go) begin
                        pc_q    <= pc4;
                        state_q <= bus.in_step_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end
                ST_STEP_WAIT: begin
                    if (!bus.in_stall) begin
                        if (bus.in_halt && bus.in_go) begin
                            state_q <= ST_HALT;
                        end else if (!bus.in_step_mode) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.out_pc       = pc_q;
    assign bus.out_link     = pc4;
    assign bus.out_link_we  = bus.in_JW & run;
    assign bus.out_run      = run;
    assign bus.out_halted   = (state_q == ST_HALT);
    assign bus.out_cycles   = cycles_q;
    assign bus.out_jumps    = jumps_q;
    assign bus.out_branches = branches_q;
    assign bus.out_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int CNT_W = 5;

    logic in_clk;
    logic in_rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.in_J      = 1'b0;
        bus.in_JW     = 1'b0;
        bus.in_JR     = 1'b0;
        bus.in_BEQ    = 1'b0;
        bus.in_BNE    = 1'b0;
        bus.in_BGEZ   = 1'b0;
        bus.in_equal  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_target = 26'h0;
        bus.in_offset = 16'h0;
        bus.in_rs     = 32'h0;
        bus.in_halt   = 1'b0;
    endtask

    initial begin
        clear_strobes();
        bus.in_go        = 1'b0;
        bus.in_step_mode = 1'b0;
        bus.in_stall     = 1'b0;

        #1 in_rst_n = 1'b0;
        #2;
        chk("rst_pc",       bus.out_pc, 32'h0);
        chk("rst_halted",   32'(bus.out_halted), 32'h0);
        chk("rst_cycles",   32'(bus.out_cycles), 32'h0);
        chk("rst_jumps",    32'(bus.out_jumps), 32'h0);
        chk("rst_branches", 32'(bus.out_branches), 32'h0);
        chk("rst_state",    32'(bus.out_state), 32'(ST_RUN));
        step();
        in_rst_n = 1'b1;

        for (int i = 0; i < 4; i++) step();
        chk("plain_pc",     bus.out_pc, 32'h10);
        chk("plain_cycles", 32'(bus.out_cycles), 32'd4);
        chk("plain_link",   bus.out_link, 32'h14);
        chk("plain_linkwe", 32'(bus.out_link_we), 32'h0);
        chk("plain_run",    32'(bus.out_run), 32'h1);

        // JR ignores the low two bits of the register value.
        bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs = 32'h43;
        step();
        clear_strobes();
        chk("jr_pc",    bus.out_pc, 32'h40);
        chk("jr_jumps", 32'(bus.out_jumps), 32'd1);

        bus.in_BEQ = 1'b1; bus.in_equal = 1'b1; bus.in_offset = 16'hFFFE;
        step();
        clear_strobes();
        chk("beq_pc",  bus.out_pc, 32'h3C);
        chk("beq_cnt", 32'(bus.out_branches), 32'd1);

        bus.in_BNE = 1'b1; bus.in_equal = 1'b1; bus.in_offset = 16'h0010;
        step();
        clear_strobes();
        chk("bne_nt_pc",  bus.out_pc, 32'h40);
        chk("bne_nt_cnt", 32'(bus.out_branches), 32'd1);

        bus.in_BGEZ = 1'b1; bus.in_sign = 1'b0; bus.in_offset = 16'h0004;
        step();
        clear_strobes();
        chk("bgez_t_pc",  bus.out_pc, 32'h54);
        chk("bgez_t_cnt", 32'(bus.out_branches), 32'd2);

        bus.in_BGEZ = 1'b1; bus.in_sign = 1'b1; bus.in_offset = 16'h0004;
        step();
        clear_strobes();
        chk("bgez_nt_pc",  bus.out_pc, 32'h58);
        chk("bgez_nt_cnt", 32'(bus.out_branches), 32'd2);

        bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs = 32'h8000_0010;
        step();
        clear_strobes();
        chk("jr2_pc", bus.out_pc, 32'h8000_0010);

        bus.in_J = 1'b1; bus.in_JW = 1'b1; bus.in_target = 26'h10;
        #1;
        chk("jal_link",   bus.out_link, 32'h8000_0014);
        chk("jal_linkwe", 32'(bus.out_link_we), 32'h1);
        step();
        clear_strobes();
        chk("jal_pc",    bus.out_pc, 32'h8000_0040);
        chk("jal_jumps", 32'(bus.out_jumps), 32'd3);

        bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs = 32'h20;
        step();
        clear_strobes();
        chk("jr3_pc",     bus.out_pc, 32'h20);
        chk("pre_cycles", 32'(bus.out_cycles), 32'd12);

        // Halt together with a jump strobe: halt wins.
        bus.in_halt = 1'b1; bus.in_J = 1'b1; bus.in_target = 26'h3;
        #1;
        chk("halt_run", 32'(bus.out_run), 32'h0);
        step();
        bus.in_halt = 1'b0;
        chk("halt_flag",  32'(bus.out_halted), 32'h1);
        chk("halt_pc",    bus.out_pc, 32'h20);
        chk("halt_jumps", 32'(bus.out_jumps), 32'd4);
        chk("halt_state", 32'(bus.out_state), 32'(ST_HALT));
        step();
        step();
        chk("halt_hold_pc",     bus.out_pc, 32'h20);
        chk("halt_hold_cycles", 32'(bus.out_cycles), 32'd13);
        chk("halt_hold_jumps",  32'(bus.out_jumps), 32'd4);
        clear_strobes();

        bus.in_go = 1'b1;
        step();
        bus.in_go = 1'b0;
        chk("resume_pc",     bus.out_pc, 32'h24);
        chk("resume_halted", 32'(bus.out_halted), 32'h0);
        chk("resume_state",  32'(bus.out_state), 32'(ST_RUN));
        chk("resume_cycles", 32'(bus.out_cycles), 32'd13);

        bus.in_step_mode = 1'b1;
        step();
        chk("step_enter_pc",    bus.out_pc, 32'h28);
        chk("step_enter_state", 32'(bus.out_state), 32'(ST_STEP_WAIT));
        step();
        step();
        chk("step_idle_pc",     bus.out_pc, 32'h28);
        chk("step_idle_cycles", 32'(bus.out_cycles), 32'd16);

        for (int i = 0; i < 3; i++) begin
            bus.in_go = 1'b1;
            step();
            bus.in_go = 1'b0;
            step();
        end
        chk("step3_pc",     bus.out_pc, 32'h34);
        chk("step3_cycles", 32'(bus.out_cycles), 32'd22);

        bus.in_go = 1'b1; bus.in_stall = 1'b1;
        #1;
        chk("stall_run", 32'(bus.out_run), 32'h0);
        step();
        chk("stall_pc",     bus.out_pc, 32'h34);
        chk("stall_cycles", 32'(bus.out_cycles), 32'd23);

        bus.in_go = 1'b0; bus.in_stall = 1'b0; bus.in_step_mode = 1'b0;
        step();
        chk("exit_step_pc",    bus.out_pc, 32'h34);
        chk("exit_step_state", 32'(bus.out_state), 32'(ST_RUN));

        bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs = 32'hFFFF_FFFC;
        step();
        clear_strobes();
        step();
        chk("wrap_pc",     bus.out_pc, 32'h0);
        chk("wrap_cycles", 32'(bus.out_cycles), 32'd26);

        for (int i = 0; i < 6; i++) step();
        chk("sat_cycles", 32'(bus.out_cycles), 32'd31);
        chk("sat_pc",     bus.out_pc, 32'h18);

        // Reset asserted between edges while a JR is presented.
        bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs = 32'h100;
        #2 in_rst_n = 1'b0;
        #1;
        chk("async_pc",       bus.out_pc, 32'h0);
        chk("async_state",    32'(bus.out_state), 32'(ST_RUN));
        chk("async_cycles",   32'(bus.out_cycles), 32'd0);
        chk("async_jumps",    32'(bus.out_jumps), 32'd0);
        chk("async_branches", 32'(bus.out_branches), 32'd0);
        step();
        in_rst_n = 1'b1;
        clear_strobes();
        step();
        chk("post_rst_pc",     bus.out_pc, 32'h4);
        chk("post_rst_cycles", 32'(bus.out_cycles), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
